// File: rtl/blood_pkg.sv
// Shared encodings for the blood-bank allocator: ABO/Rh type codes, FSM states and the
// donor/recipient compatibility rule (a donor may not carry an antigen the recipient lacks).
package blood_pkg;

   localparam int NUM_TYPES = 8;

   // bit2 = B antigen, bit1 = A antigen, bit0 = Rh+
   typedef enum logic [2:0] {
      BT_O_NEG  = 3'd0,
      BT_O_POS  = 3'd1,
      BT_A_NEG  = 3'd2,
      BT_A_POS  = 3'd3,
      BT_B_NEG  = 3'd4,
      BT_B_POS  = 3'd5,
      BT_AB_NEG = 3'd6,
      BT_AB_POS = 3'd7
   } blood_type_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCAN,
      ST_RESP
   } state_t;

   function automatic logic blood_compat(input logic [2:0] donor, input logic [2:0] recip);
      return (donor & ~recip) == 3'b000;
   endfunction

endpackage

// File: rtl/blood_inventory.sv
// Bank of saturating per-type unit counters; 1-cycle update, overflow is a registered pulse.
// Increment and decrement on the same type cancel, so a unit donated mid-scan can be granted.
module blood_inventory
   import blood_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                inc_vld,
   input  logic [2:0]                          inc_type,
   input  logic                                dec_vld,
   input  logic [2:0]                          dec_type,
   output logic                                ovf_o,
   output logic [NUM_TYPES-1:0][CNT_W-1:0]     cnt_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [NUM_TYPES-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [NUM_TYPES-1:0]            inc_hit, dec_hit;
   logic                            ovf_q, ovf_d;

   always_comb begin
      cnt_d   = cnt_q;
      ovf_d   = 1'b0;
      inc_hit = '0;
      dec_hit = '0;
      for (int t = 0; t < NUM_TYPES; t++) begin
         inc_hit[t] = inc_vld && (inc_type == 3'(t));
         dec_hit[t] = dec_vld && (dec_type == 3'(t));
         if (inc_hit[t] && !dec_hit[t]) begin
            if (cnt_q[t] == CNT_MAX) ovf_d = 1'b1;
            else                     cnt_d[t] = cnt_q[t] + 1'b1;
         end else if (dec_hit[t] && !inc_hit[t]) begin
            cnt_d[t] = cnt_q[t] - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   assign cnt_o = cnt_q;
   assign ovf_o = ovf_q;

endmodule

// File: rtl/blood_bank_allocator.sv
// Per-type blood inventory with a descending compatibility scan: 1..R+1 cycles accept-to-response,
// response held until rsp_ready, no new request taken outside IDLE. Optional stats: BLOOD_ALLOC_STATS_EN.
module blood_bank_allocator
   import blood_pkg::*;
#(
   parameter int CNT_W      = 8,
   parameter int LOW_THRESH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        don_valid,
   input  logic [2:0]  don_type,
   output logic        don_overflow,
   input  logic        req_valid,
   input  logic [2:0]  req_type,
   output logic        req_ready,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_grant,
   output logic [2:0]  rsp_type,
   output logic [7:0]  low_stock
`ifdef BLOOD_ALLOC_STATS_EN
   ,
   output logic [15:0] stat_grants,
   output logic [15:0] stat_denials
`endif
);

   localparam logic [CNT_W-1:0] LOW_TH = CNT_W'(LOW_THRESH);

   logic [NUM_TYPES-1:0][CNT_W-1:0] cnt;
   state_t      state_q;
   logic [2:0]  recip_q, idx_q, rsp_type_q;
   logic        rsp_valid_q, rsp_grant_q;
   logic        avail, dec_vld;

   // A donation landing on the candidate this cycle counts as stock.
   assign avail   = (cnt[idx_q] != '0) || (don_valid && (don_type == idx_q));
   assign dec_vld = (state_q == ST_SCAN) && blood_compat(idx_q, recip_q) && avail;

   blood_inventory #(.CNT_W(CNT_W)) u_inv (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc_vld  (don_valid),
      .inc_type (don_type),
      .dec_vld  (dec_vld),
      .dec_type (idx_q),
      .ovf_o    (don_overflow),
      .cnt_o    (cnt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         recip_q     <= 3'b000;
         idx_q       <= 3'b000;
         rsp_valid_q <= 1'b0;
         rsp_grant_q <= 1'b0;
         rsp_type_q  <= 3'b000;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_valid) begin
                  recip_q <= req_type;
                  idx_q   <= req_type;
                  state_q <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               if (dec_vld) begin
                  rsp_grant_q <= 1'b1;
                  rsp_type_q  <= idx_q;
                  rsp_valid_q <= 1'b1;
                  state_q     <= ST_RESP;
               end else if (idx_q == 3'b000) begin
                  rsp_grant_q <= 1'b0;
                  rsp_type_q  <= 3'b000;
                  rsp_valid_q <= 1'b1;
                  state_q     <= ST_RESP;
               end else begin
                  idx_q <= idx_q - 3'd1;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  rsp_grant_q <= 1'b0;
                  rsp_type_q  <= 3'b000;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign req_ready = (state_q == ST_IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_grant = rsp_grant_q;
   assign rsp_type  = rsp_type_q;

   always_comb begin
      low_stock = '0;
      for (int t = 0; t < NUM_TYPES; t++) low_stock[t] = (cnt[t] <= LOW_TH);
   end

`ifdef BLOOD_ALLOC_STATS_EN
   logic [15:0] grants_q, denials_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grants_q  <= 16'h0000;
         denials_q <= 16'h0000;
      end else if ((state_q == ST_RESP) && rsp_ready) begin
         if (rsp_grant_q && (grants_q != 16'hFFFF))        grants_q  <= grants_q + 16'd1;
         else if (!rsp_grant_q && (denials_q != 16'hFFFF)) denials_q <= denials_q + 16'd1;
      end
   end

   assign stat_grants  = grants_q;
   assign stat_denials = denials_q;
`endif

endmodule

// File: tb/tb_blood_bank_allocator.sv
// Self-checking bench: vector table, hand sequences for corner cases, random traffic vs a queue-free model.
module tb_blood_bank_allocator;

   logic       clk, rst_n;
   logic       don_valid, req_valid, rsp_ready;
   logic [2:0] don_type, req_type;
   logic       don_overflow, req_ready, rsp_valid, rsp_grant;
   logic [2:0] rsp_type;
   logic [7:0] low_stock;
   logic       ovf2, req_ready2, rsp_valid2, rsp_grant2;
   logic [2:0] rsp_type2;
   logic [7:0] low2;
`ifdef BLOOD_ALLOC_STATS_EN
   logic [15:0] sg, sd, sg2, sd2;
`endif

   int tests_run = 0;
   int tests_failed = 0;
   int mcnt [8];

   blood_bank_allocator dut (
      .clk(clk), .rst_n(rst_n), .don_valid(don_valid), .don_type(don_type),
      .don_overflow(don_overflow), .req_valid(req_valid), .req_type(req_type),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_grant(rsp_grant), .rsp_type(rsp_type), .low_stock(low_stock)
`ifdef BLOOD_ALLOC_STATS_EN
      , .stat_grants(sg), .stat_denials(sd)
`endif
   );

   blood_bank_allocator #(.CNT_W(2)) dut_c2 (
      .clk(clk), .rst_n(rst_n), .don_valid(don_valid), .don_type(don_type),
      .don_overflow(ovf2), .req_valid(req_valid), .req_type(req_type),
      .req_ready(req_ready2), .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready),
      .rsp_grant(rsp_grant2), .rsp_type(rsp_type2), .low_stock(low2)
`ifdef BLOOD_ALLOC_STATS_EN
      , .stat_grants(sg2), .stat_denials(sd2)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [2:0] da_t; int da_n;
      logic [2:0] db_t; int db_n;
      logic [2:0] req;
      logic       g;
      logic [2:0] ty;
      int         lat;
      logic [7:0] low;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      tests_run++;
      if (act !== want) begin
         tests_failed++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, want);
      end
   endtask

   function automatic logic [7:0] model_low();
      logic [7:0] l;
      for (int t = 0; t < 8; t++) l[t] = (mcnt[t] <= 2);
      return l;
   endfunction

   // Reference: try donor types from the recipient's own code down to O-, first compatible in stock wins.
   task automatic model_req(input logic [2:0] r, output logic g, output logic [2:0] ty, output int lat);
      g = 1'b0; ty = 3'b000; lat = int'(r) + 1;
      for (int d = int'(r); d >= 0; d--) begin
         logic [2:0] dd;
         dd = 3'(d);
         if (((dd & ~r) == 3'b000) && (mcnt[d] > 0)) begin
            g = 1'b1; ty = dd; lat = int'(r) - d + 1;
            mcnt[d]--;
            break;
         end
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; don_valid = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
      don_type = 3'b000; req_type = 3'b000;
      for (int t = 0; t < 8; t++) mcnt[t] = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", req_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_grant_type", {rsp_grant, rsp_type}, 0);
      chk("rst_ovf", don_overflow, 0);
      chk("rst_low_stock", low_stock, 8'hFF);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic donate(input logic [2:0] t);
      logic exp_ovf;
      exp_ovf = (mcnt[t] == 255);
      if (!exp_ovf) mcnt[t]++;
      @(negedge clk);
      don_valid = 1'b1; don_type = t;
      @(posedge clk);
      #1;
      don_valid = 1'b0;
      chk("don_overflow", don_overflow, exp_ovf);
   endtask

   task automatic accept(input logic [2:0] r);
      @(negedge clk);
      chk("req_ready_idle", req_ready, 1);
      req_valid = 1'b1; req_type = r;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int lat);
      lat = 0;
      while (!rsp_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (!rsp_valid) chk("rsp_timeout", 0, 1);
   endtask

   task automatic do_req(input logic [2:0] r, output logic g, output logic [2:0] ty, output int lat);
      accept(r);
      wait_rsp(lat);
      g = rsp_grant; ty = rsp_type;
      @(posedge clk);
      #1;
      chk("rsp_valid_fall", rsp_valid, 0);
   endtask

   initial begin
      logic       g, mg;
      logic [2:0] ty, mty;
      int         lat, mlat;

      //            da_t   n  db_t   n  req    g  ty     lat low
      vecs[0] = '{3'b000, 0, 3'b000, 0, 3'b111, 0, 3'b000, 8, 8'hFF};
      vecs[1] = '{3'b010, 2, 3'b000, 0, 3'b011, 1, 3'b010, 2, 8'hFF};
      vecs[2] = '{3'b000, 1, 3'b111, 1, 3'b111, 1, 3'b111, 1, 8'hFF};
      vecs[3] = '{3'b110, 3, 3'b000, 0, 3'b111, 1, 3'b110, 2, 8'hFF};
      vecs[4] = '{3'b001, 4, 3'b000, 0, 3'b010, 0, 3'b000, 3, 8'hFD};
      vecs[5] = '{3'b000, 3, 3'b000, 0, 3'b100, 1, 3'b000, 5, 8'hFF};
      vecs[6] = '{3'b101, 5, 3'b000, 0, 3'b101, 1, 3'b101, 1, 8'hDF};
      vecs[7] = '{3'b011, 3, 3'b000, 0, 3'b110, 0, 3'b000, 7, 8'hF7};

      for (int i = 0; i < 8; i++) begin
         do_reset();
         for (int k = 0; k < vecs[i].da_n; k++) donate(vecs[i].da_t);
         for (int k = 0; k < vecs[i].db_n; k++) donate(vecs[i].db_t);
         model_req(vecs[i].req, mg, mty, mlat);
         do_req(vecs[i].req, g, ty, lat);
         chk($sformatf("vec%0d_grant", i), g, vecs[i].g);
         chk($sformatf("vec%0d_type", i), ty, vecs[i].ty);
         chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
         chk($sformatf("vec%0d_low", i), low_stock, vecs[i].low);
      end
      // After vec 1 style stock (A- x2, one granted) a second A+ request still finds A-.
      do_reset();
      donate(3'b010); donate(3'b010);
      do_req(3'b011, g, ty, lat);
      do_req(3'b011, g, ty, lat);
      chk("a_neg_second_type", {g, ty}, {1'b1, 3'b010});
      do_req(3'b011, g, ty, lat);
      chk("a_neg_exhausted", {g, ty}, 4'b0000);

      // Narrow counters: fourth donation saturates.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         donate(3'b101);
         chk($sformatf("c2_ovf_%0d", i), ovf2, (i == 3));
      end
      @(posedge clk);
      #1;
      chk("c2_ovf_pulse_end", ovf2, 0);
      chk("c2_low_b_pos", low2[5], 0);

      // Donation on the candidate type during its SCAN cycle: stock 1 and stock 0.
      for (int s = 1; s >= 0; s--) begin
         do_reset();
         if (s == 1) donate(3'b011);
         accept(3'b011);
         don_valid = 1'b1; don_type = 3'b011;
         @(posedge clk);
         #1;
         don_valid = 1'b0;
         chk($sformatf("same_cyc%0d_rsp", s), {rsp_valid, rsp_grant, rsp_type}, {2'b11, 3'b011});
         chk($sformatf("same_cyc%0d_ovf", s), don_overflow, 0);
         @(posedge clk);
         #1;
         if (s == 1) begin
            do_req(3'b011, g, ty, lat);
            chk("same_cyc1_left", {g, ty}, {1'b1, 3'b011});
         end
         do_req(3'b011, g, ty, lat);
         chk($sformatf("same_cyc%0d_empty", s), {g, ty, 4'(lat)}, {1'b0, 3'b000, 4'd4});
      end

      // Response stall.
      do_reset();
      donate(3'b000);
      rsp_ready = 1'b0;
      accept(3'b010);
      wait_rsp(lat);
      chk("stall_lat", lat, 3);
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         chk($sformatf("stall_hold_%0d", c), {rsp_valid, rsp_grant, rsp_type, req_ready}, {2'b11, 3'b000, 1'b0});
      end
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("stall_release", {rsp_valid, req_ready}, 2'b01);

      // Reset in the middle of a scan.
      do_reset();
      for (int k = 0; k < 3; k++) donate(3'b000);
      chk("pre_rst_low", low_stock[0], 0);
      accept(3'b111);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midscan_rst", {req_ready, rsp_valid, rsp_grant, rsp_type, don_overflow}, {1'b1, 6'b0});
      chk("midscan_rst_low", low_stock, 8'hFF);

      // Random traffic against the model.
      do_reset();
      for (int it = 0; it < 150; it++) begin
         int nd;
         logic [2:0] r;
         nd = $urandom_range(0, 3);
         for (int k = 0; k < nd; k++) donate(3'($urandom_range(0, 7)));
         r = 3'($urandom_range(0, 7));
         model_req(r, mg, mty, mlat);
         do_req(r, g, ty, lat);
         chk($sformatf("rnd%0d_rsp r=%0d", it, r), {g, ty, 8'(lat)}, {mg, mty, 8'(mlat)});
         chk($sformatf("rnd%0d_low", it), low_stock, model_low());
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
